// File: rtl/host_pkg.sv
// host_pkg: shared state encoding and width helper for the host sequencer
package host_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_CRST    = 4'd2,
      S_REQ     = 4'd3,
      S_RUN     = 4'd4,
      S_RB_ADDR = 4'd5,
      S_RB_WAIT = 4'd6,
      S_FIN     = 4'd7,
      S_ERR     = 4'd8
   } host_state_t;

   // counter must hold the value TIMEOUT itself, hence one extra bit
   function automatic int host_cw(input int timeout);
      return $clog2(timeout) + 1;
   endfunction

endpackage

// File: rtl/host_tmo_ctr.sv
// host_tmo_ctr: run-cycle counter with timeout compare
//   clk, reset : clock, sync active-high reset
//   clr_i      : zero the counter
//   en_i       : count one cycle
//   cnt_o      : current count
//   expired_o  : count has reached TIMEOUT-1
module host_tmo_ctr
   import host_pkg::*;
#(
   parameter int TIMEOUT = 4096,
   parameter int CW      = host_cw(TIMEOUT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          expired_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk)
      cnt_q <= (reset || clr_i) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

   assign cnt_o     = cnt_q;
   assign expired_o = cnt_q == CW'(TIMEOUT - 1);

endmodule

// File: rtl/core_host_ctrl.sv
// core_host_ctrl: host sequencer - preload memory, reset/start core, await done, read results back
//   load stream : ld_valid/ld_ready/ld_addr/ld_data/ld_last
//   core side   : core_reset, core_req, core_done
//   memory port : mem_wr_en, mem_addr, mem_wr_data, mem_rd_data (1-cycle read latency)
//   result      : res_valid/res_ready/res_data
//   status      : busy, done (pulse), timeout (sticky), cycle_cnt
module core_host_ctrl
   import host_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int RST_CYC  = 2,
   parameter int TIMEOUT  = 4096,
   parameter int RB_BASE  = 0,
   parameter int RB_COUNT = 4,
   parameter int CW       = host_cw(TIMEOUT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          core_reset,
   output logic          core_req,
   input  logic          core_done,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wr_data,
   input  logic [DW-1:0] mem_rd_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycle_cnt
);

   localparam int            RW       = $clog2(RST_CYC + 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
   localparam logic [AW-1:0] RB_LAST  = AW'(RB_COUNT - 1);
   localparam logic [AW-1:0] BASE     = AW'(RB_BASE);

   host_state_t   state_q, state_d;
   logic [RW-1:0] rst_cnt_q;
   logic [AW-1:0] idx_q, idx_d;
   logic          ld_ready_q, core_reset_q, core_req_q, done_q, busy_q, timeout_q;
   logic          mem_wr_en_q, res_valid_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wr_data_q, res_data_q;
   logic          ld_acc, rb_acc, expired;

   // ld_ready_q is high exactly in LOAD, res_valid_q only in RB_WAIT
   assign ld_acc = ld_ready_q && ld_valid;
   assign rb_acc = res_valid_q && res_ready;
   assign idx_d  = (state_q == S_RUN) ? '0 : rb_acc ? idx_q + 1'b1 : idx_q;

   host_tmo_ctr #(.TIMEOUT(TIMEOUT), .CW(CW)) u_tmo (
      .clk       (clk),
      .reset     (reset),
      .clr_i     ((state_q == S_IDLE && start) || state_q == S_REQ),
      .en_i      (state_q == S_RUN),
      .cnt_o     (cycle_cnt),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    state_d = start ? S_LOAD : S_IDLE;
         S_LOAD:    state_d = (ld_acc && ld_last) ? S_CRST : S_LOAD;
         S_CRST:    state_d = (rst_cnt_q == RST_LAST) ? S_REQ : S_CRST;
         S_REQ:     state_d = S_RUN;
         S_RUN:     state_d = core_done ? (RB_COUNT == 0 ? S_FIN : S_RB_ADDR) : expired ? S_ERR : S_RUN;
         S_RB_ADDR: state_d = S_RB_WAIT;
         S_RB_WAIT: state_d = !rb_acc ? S_RB_WAIT : (idx_q == RB_LAST) ? S_FIN : S_RB_ADDR;
         default:   state_d = S_IDLE;
      endcase
   end

   // outputs are registered from the next state so they line up with state_q
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ld_ready_q    <= 1'b0;
         core_reset_q  <= 1'b1;
         core_req_q    <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
         rst_cnt_q     <= '0;
         idx_q         <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         ld_ready_q    <= state_d == S_LOAD;
         core_reset_q  <= !(state_d inside {S_REQ, S_RUN});
         core_req_q    <= state_d == S_REQ;
         done_q        <= state_d == S_FIN;
         busy_q        <= state_d != S_IDLE;
         timeout_q     <= (state_d == S_ERR) || (timeout_q && !(state_q == S_IDLE && start));
         rst_cnt_q     <= (state_q == S_CRST) ? rst_cnt_q + 1'b1 : '0;
         idx_q         <= idx_d;
         mem_wr_en_q   <= ld_acc;
         mem_wr_data_q <= ld_acc ? ld_data : '0;
         mem_addr_q    <= ld_acc ? ld_addr :
                          (state_d == S_RB_ADDR) ? BASE + idx_d :
                          (state_d == S_RB_WAIT) ? mem_addr_q : '0;
         // first RB_WAIT cycle captures read data, then hold until accepted
         res_valid_q   <= (state_q == S_RB_WAIT) && (!res_valid_q || !res_ready);
         res_data_q    <= (state_q == S_RB_WAIT && !res_valid_q) ? mem_rd_data : res_data_q;
      end
   end

   assign ld_ready    = ld_ready_q;
   assign core_reset  = core_reset_q;
   assign core_req    = core_req_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign timeout     = timeout_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;

endmodule

// File: tb/tb_core_host_ctrl.sv
// tb_core_host_ctrl: directed self-checking bench for core_host_ctrl
module tb_core_host_ctrl;

   logic        clk = 1'b0, reset = 1'b1, mem_clr = 1'b1;
   logic        start = 1'b0, start_t = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic        core_done = 1'b0, res_ready = 1'b0;
   logic [7:0]  ld_addr = 8'h00, ld_data = 8'h00;
   logic        ld_ready, core_reset, core_req, mem_wr_en, res_valid, busy, done, timeout;
   logic [7:0]  mem_addr, mem_wr_data, mem_rd_data, res_data;
   logic [12:0] cycle_cnt;
   logic        ld_ready_t, core_reset_t, core_req_t, mem_wr_en_t, res_valid_t, busy_t, done_t, timeout_t;
   logic [7:0]  mem_addr_t, mem_wr_data_t, res_data_t;
   logic [4:0]  cycle_cnt_t;
   logic [7:0]  mem [256];
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   core_host_ctrl #(.AW(8), .DW(8), .RST_CYC(2), .TIMEOUT(4096), .RB_BASE(0), .RB_COUNT(2)) dut (
      .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset),
      .core_req(core_req), .core_done(core_done), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .busy(busy), .done(done),
      .timeout(timeout), .cycle_cnt(cycle_cnt)
   );

   core_host_ctrl #(.AW(8), .DW(8), .RST_CYC(2), .TIMEOUT(16), .RB_BASE(0), .RB_COUNT(2)) dut_t (
      .clk(clk), .reset(reset), .start(start_t), .ld_valid(ld_valid), .ld_ready(ld_ready_t),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset_t),
      .core_req(core_req_t), .core_done(1'b0), .mem_wr_en(mem_wr_en_t), .mem_addr(mem_addr_t),
      .mem_wr_data(mem_wr_data_t), .mem_rd_data(8'h00), .res_valid(res_valid_t),
      .res_ready(res_ready), .res_data(res_data_t), .busy(busy_t), .done(done_t),
      .timeout(timeout_t), .cycle_cnt(cycle_cnt_t)
   );

   always @(posedge clk) begin
      if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      tick; tick;
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%0b exp=1", core_reset); end
      checks++; if ({ld_ready, core_req, mem_wr_en, res_valid, busy, done, timeout} !== 7'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0000000", {ld_ready, core_req, mem_wr_en, res_valid, busy, done, timeout}); end
      checks++; if (cycle_cnt !== 13'd0 || mem_addr !== 8'h00) begin failures++; $display("FAIL reset_cnt_addr cnt=%0d addr=%0h exp=0/0", cycle_cnt, mem_addr); end
      reset = 1'b0; mem_clr = 1'b0;
   endtask

   task automatic test_load;
      start = 1'b1; tick; start = 1'b0;
      checks++; if (ld_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL load_enter ready=%0b busy=%0b exp=1/1", ld_ready, busy); end
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1; ld_addr = 8'(k + 1); ld_data = 8'(8'h10 + k); ld_last = (k == 3); start = (k == 1);
         tick;
         checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'(k + 1) || mem_wr_data !== 8'(8'h10 + k)) begin failures++; $display("FAIL load_write%0d en=%0b addr=%0h data=%0h exp=1/%0h/%0h", k, mem_wr_en, mem_addr, mem_wr_data, k + 1, 8'h10 + k); end
      end
      ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
      checks++; if (core_reset !== 1'b1 || ld_ready !== 1'b0 || core_req !== 1'b0) begin failures++; $display("FAIL crst1 rst=%0b ready=%0b req=%0b exp=1/0/0", core_reset, ld_ready, core_req); end
      tick;
      checks++; if (core_reset !== 1'b1 || mem_wr_en !== 1'b0 || core_req !== 1'b0) begin failures++; $display("FAIL crst2 rst=%0b wr=%0b req=%0b exp=1/0/0", core_reset, mem_wr_en, core_req); end
      tick;
      checks++; if (core_req !== 1'b1 || core_reset !== 1'b0) begin failures++; $display("FAIL req req=%0b rst=%0b exp=1/0", core_req, core_reset); end
   endtask

   task automatic test_run;
      for (int i = 1; i <= 50; i++) begin
         tick;
         start = (i == 20);
         if (i == 1) begin
            checks++; if (core_req !== 1'b0 || core_reset !== 1'b0 || cycle_cnt !== 13'd0) begin failures++; $display("FAIL run_first req=%0b rst=%0b cnt=%0d exp=0/0/0", core_req, core_reset, cycle_cnt); end
         end
      end
      checks++; if (cycle_cnt !== 13'd49 || busy !== 1'b1) begin failures++; $display("FAIL run_cnt49 cnt=%0d busy=%0b exp=49/1", cycle_cnt, busy); end
      core_done = 1'b1; tick; core_done = 1'b0;
      checks++; if (cycle_cnt !== 13'd50) begin failures++; $display("FAIL run_cycle_cnt got=%0d exp=50", cycle_cnt); end
      checks++; if (core_reset !== 1'b1 || res_valid !== 1'b0 || mem_addr !== 8'h00 || done !== 1'b0) begin failures++; $display("FAIL rb_addr0 rst=%0b rv=%0b addr=%0h done=%0b exp=1/0/0/0", core_reset, res_valid, mem_addr, done); end
      tick;
      checks++; if (cycle_cnt !== 13'd50) begin failures++; $display("FAIL cnt_frozen got=%0d exp=50", cycle_cnt); end
      tick;
      checks++; if (res_valid !== 1'b1 || res_data !== 8'hEE) begin failures++; $display("FAIL rb_byte0 rv=%0b data=%0h exp=1/ee", res_valid, res_data); end
   endtask

   task automatic test_readback;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (res_valid !== 1'b1 || res_data !== 8'hEE || mem_addr !== 8'h00) begin failures++; $display("FAIL stall%0d rv=%0b data=%0h addr=%0h exp=1/ee/0", i, res_valid, res_data, mem_addr); end
      end
      res_ready = 1'b1; tick;
      checks++; if (res_valid !== 1'b0 || mem_addr !== 8'h01) begin failures++; $display("FAIL rb_addr1 rv=%0b addr=%0h exp=0/1", res_valid, mem_addr); end
      tick; tick;
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h10) begin failures++; $display("FAIL rb_byte1 rv=%0b data=%0h exp=1/10", res_valid, res_data); end
      tick; res_ready = 1'b0;
      checks++; if (done !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL fin done=%0b rv=%0b exp=1/0", done, res_valid); end
      tick;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1 || cycle_cnt !== 13'd50) begin failures++; $display("FAIL idle_after done=%0b busy=%0b rst=%0b cnt=%0d exp=0/0/1/50", done, busy, core_reset, cycle_cnt); end
   endtask

   task automatic test_back_to_back;
      start = 1'b1; tick; start = 1'b0;
      ld_valid = 1'b1; ld_addr = 8'h05; ld_data = 8'hA5; ld_last = 1'b0; tick;
      checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'h05 || mem_wr_data !== 8'hA5) begin failures++; $display("FAIL b2b_w0 en=%0b addr=%0h data=%0h exp=1/5/a5", mem_wr_en, mem_addr, mem_wr_data); end
      ld_addr = 8'h00; ld_data = 8'h5A; ld_last = 1'b1; tick;
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'h00 || mem_wr_data !== 8'h5A) begin failures++; $display("FAIL b2b_w1 en=%0b addr=%0h data=%0h exp=1/0/5a", mem_wr_en, mem_addr, mem_wr_data); end
      tick; tick; tick;
      core_done = 1'b1; tick; core_done = 1'b0;
      checks++; if (cycle_cnt !== 13'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", cycle_cnt); end
      res_ready = 1'b1; tick; tick;
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h5A) begin failures++; $display("FAIL b2b_byte0 rv=%0b data=%0h exp=1/5a", res_valid, res_data); end
      tick; tick; tick;
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h10) begin failures++; $display("FAIL b2b_byte1 rv=%0b data=%0h exp=1/10", res_valid, res_data); end
      tick; res_ready = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done); end
      tick;
   endtask

   task automatic test_timeout;
      start_t = 1'b1; tick; start_t = 1'b0;
      checks++; if (ld_ready_t !== 1'b1 || timeout_t !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL to_load ready_t=%0b to=%0b ready=%0b exp=1/0/0", ld_ready_t, timeout_t, ld_ready); end
      ld_valid = 1'b1; ld_addr = 8'h09; ld_data = 8'h55; ld_last = 1'b1; tick;
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++; if (mem_wr_en_t !== 1'b1 || mem_addr_t !== 8'h09 || mem_wr_data_t !== 8'h55) begin failures++; $display("FAIL to_write en=%0b addr=%0h data=%0h exp=1/9/55", mem_wr_en_t, mem_addr_t, mem_wr_data_t); end
      tick; tick;
      checks++; if (core_req_t !== 1'b1) begin failures++; $display("FAIL to_req got=%0b exp=1", core_req_t); end
      for (int i = 1; i <= 16; i++) begin
         tick;
         checks++; if (done_t !== 1'b0 || timeout_t !== 1'b0) begin failures++; $display("FAIL to_run%0d done=%0b to=%0b exp=0/0", i, done_t, timeout_t); end
      end
      checks++; if (cycle_cnt_t !== 5'd15) begin failures++; $display("FAIL to_cnt15 got=%0d exp=15", cycle_cnt_t); end
      tick;
      checks++; if (timeout_t !== 1'b1 || core_reset_t !== 1'b1 || done_t !== 1'b0 || cycle_cnt_t !== 5'd16) begin failures++; $display("FAIL to_err to=%0b rst=%0b done=%0b cnt=%0d exp=1/1/0/16", timeout_t, core_reset_t, done_t, cycle_cnt_t); end
      tick;
      checks++; if (timeout_t !== 1'b1 || done_t !== 1'b0 || busy_t !== 1'b0) begin failures++; $display("FAIL to_idle to=%0b done=%0b busy=%0b exp=1/0/0", timeout_t, done_t, busy_t); end
      start_t = 1'b1; tick; start_t = 1'b0;
      checks++; if (timeout_t !== 1'b0 || cycle_cnt_t !== 5'd0 || busy_t !== 1'b1) begin failures++; $display("FAIL to_clear to=%0b cnt=%0d busy=%0b exp=0/0/1", timeout_t, cycle_cnt_t, busy_t); end
   endtask

   task automatic test_reset_mid;
      start = 1'b1; tick; start = 1'b0;
      ld_valid = 1'b1; ld_addr = 8'h07; ld_data = 8'h77; ld_last = 1'b1; tick;
      ld_valid = 1'b0; ld_last = 1'b0;
      tick; tick; tick; tick;
      checks++; if (core_reset !== 1'b0 || cycle_cnt !== 13'd1) begin failures++; $display("FAIL mid_run rst=%0b cnt=%0d exp=0/1", core_reset, cycle_cnt); end
      reset = 1'b1; tick; reset = 1'b0;
      checks++; if (core_reset !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || cycle_cnt !== 13'd0) begin failures++; $display("FAIL mid_reset rst=%0b busy=%0b rv=%0b cnt=%0d exp=1/0/0/0", core_reset, busy, res_valid, cycle_cnt); end
      start = 1'b1; tick; start = 1'b0;
      ld_valid = 1'b1; ld_last = 1'b1; tick;
      ld_valid = 1'b0; ld_last = 1'b0;
      tick; tick; tick;
      core_done = 1'b1; tick; core_done = 1'b0;
      tick; tick;
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rb_pending rv=%0b exp=1", res_valid); end
      reset = 1'b1; tick; reset = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1) begin failures++; $display("FAIL rb_reset rv=%0b busy=%0b rst=%0b exp=0/0/1", res_valid, busy, core_reset); end
      tick;
   endtask

   initial begin
      test_reset;
      test_load;
      test_run;
      test_readback;
      test_back_to_back;
      test_timeout;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
